// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detection.
// Define EXEC_FWD_EN to build the EX/MEM and MEM/WB forwarding muxes; without it RAW hazards stall.
module id_ex_operand_stage #(
   parameter int unsigned W   = 32,
   parameter int unsigned RW  = 5,
   parameter int unsigned OPW = 4
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           id_valid,
   input  logic [OPW-1:0] id_aluOP,
   input  logic [RW-1:0]  id_rs,
   input  logic [RW-1:0]  id_rt,
   input  logic [RW-1:0]  id_rd,
   input  logic [W-1:0]   id_rs_data,
   input  logic [W-1:0]   id_rt_data,
   input  logic [W-1:0]   id_imm,
   input  logic           id_use_imm,
   input  logic           id_uses_rt,
   input  logic           id_regwrite,
   input  logic           id_memread,
   input  logic           stall,
   input  logic           flush,
   input  logic           exmem_regwrite,
   input  logic [RW-1:0]  exmem_rd,
   input  logic [W-1:0]   exmem_result,
   input  logic           memwb_regwrite,
   input  logic [RW-1:0]  memwb_rd,
   input  logic [W-1:0]   memwb_result,
   output logic           hazard_stall,
   output logic           ex_valid,
   output logic [OPW-1:0] ex_aluOP,
   output logic [W-1:0]   ex_lvalue,
   output logic [W-1:0]   ex_rvalue,
   output logic [W-1:0]   ex_store_data,
   output logic [RW-1:0]  ex_rd,
   output logic           ex_regwrite,
   output logic           ex_memread
);

   typedef struct packed {
      logic           valid;
      logic [OPW-1:0] aluop;
      logic [RW-1:0]  rs;
      logic [RW-1:0]  rt;
      logic [RW-1:0]  rd;
      logic [W-1:0]   rs_data;
      logic [W-1:0]   rt_data;
      logic [W-1:0]   imm;
      logic           use_imm;
      logic           regwrite;
      logic           memread;
   } stage_t;

   stage_t stage_q;
   stage_t stage_d;

   logic          load_use_c;
   logic          raw_c;
   logic [W-1:0]  rs_fwd_c;
   logic [W-1:0]  rt_fwd_c;

   // MEM/WB retiring a write to a real (nonzero) register index
   function automatic logic wb_hit(input logic [RW-1:0] idx);
      return memwb_regwrite && (memwb_rd != '0) && (memwb_rd == idx);
   endfunction

   // destination collides with a source the ID instruction actually reads
   function automatic logic id_src_match(input logic [RW-1:0] dst);
      return (dst != '0) && ((dst == id_rs) || (id_uses_rt && (dst == id_rt)));
   endfunction

   assign load_use_c = stage_q.valid & stage_q.memread & id_src_match(stage_q.rd);

`ifdef EXEC_FWD_EN
   function automatic logic [W-1:0] fwd(input logic [RW-1:0] idx, input logic [W-1:0] latched);
      if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == idx)) return exmem_result;
      if (wb_hit(idx)) return memwb_result;
      return latched;
   endfunction

   assign raw_c    = 1'b0;
   assign rs_fwd_c = fwd(stage_q.rs, stage_q.rs_data);
   assign rt_fwd_c = fwd(stage_q.rt, stage_q.rt_data);
`else
   // without bypass paths, any in-flight producer not yet in MEM/WB must be waited out
   logic unused_exmem_result;
   assign unused_exmem_result = ^exmem_result;

   assign raw_c    = (stage_q.valid & stage_q.regwrite & id_src_match(stage_q.rd))
                   | (exmem_regwrite & id_src_match(exmem_rd));
   assign rs_fwd_c = stage_q.rs_data;
   assign rt_fwd_c = stage_q.rt_data;
`endif

   assign hazard_stall = id_valid & ~flush & (load_use_c | raw_c);

   // next stage contents: flush > stall > hazard bubble > load
   always_comb begin
      stage_d = stage_q;
      if (flush || (!stall && hazard_stall)) begin
         stage_d.valid    = 1'b0;
         stage_d.regwrite = 1'b0;
         stage_d.memread  = 1'b0;
         stage_d.aluop    = '0;
         stage_d.rd       = '0;
      end else if (stall) begin
         if (wb_hit(stage_q.rs)) stage_d.rs_data = memwb_result;
         if (wb_hit(stage_q.rt)) stage_d.rt_data = memwb_result;
      end else begin
         stage_d.valid    = id_valid;
         stage_d.aluop    = id_aluOP;
         stage_d.rs       = id_rs;
         stage_d.rt       = id_rt;
         stage_d.rd       = id_rd;
         stage_d.rs_data  = wb_hit(id_rs) ? memwb_result : id_rs_data;
         stage_d.rt_data  = wb_hit(id_rt) ? memwb_result : id_rt_data;
         stage_d.imm      = id_imm;
         stage_d.use_imm  = id_use_imm;
         stage_d.regwrite = id_regwrite & id_valid;
         stage_d.memread  = id_memread & id_valid;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) stage_q <= '0;
      else          stage_q <= stage_d;
   end

   assign ex_valid      = stage_q.valid;
   assign ex_aluOP      = stage_q.aluop;
   assign ex_rd         = stage_q.rd;
   assign ex_regwrite   = stage_q.regwrite;
   assign ex_memread    = stage_q.memread;
   assign ex_lvalue     = rs_fwd_c;
   assign ex_rvalue     = stage_q.use_imm ? stage_q.imm : rt_fwd_c;
   assign ex_store_data = rt_fwd_c;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed self-checking bench for id_ex_operand_stage; expectations follow EXEC_FWD_EN.
module tb_id_ex_operand_stage;

   logic        clk;
   logic        reset_n;
   logic        id_valid;
   logic [3:0]  id_aluOP;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic [31:0] id_rs_data, id_rt_data, id_imm;
   logic        id_use_imm, id_uses_rt, id_regwrite, id_memread;
   logic        stall, flush;
   logic        exmem_regwrite, memwb_regwrite;
   logic [4:0]  exmem_rd, memwb_rd;
   logic [31:0] exmem_result, memwb_result;
   logic        hazard_stall, ex_valid, ex_regwrite, ex_memread;
   logic [3:0]  ex_aluOP;
   logic [31:0] ex_lvalue, ex_rvalue, ex_store_data;
   logic [4:0]  ex_rd;

   int n_checks = 0;
   int n_fail   = 0;

   id_ex_operand_stage dut (
      .clk(clk), .reset_n(reset_n),
      .id_valid(id_valid), .id_aluOP(id_aluOP),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .id_use_imm(id_use_imm), .id_uses_rt(id_uses_rt),
      .id_regwrite(id_regwrite), .id_memread(id_memread),
      .stall(stall), .flush(flush),
      .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
      .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_aluOP(ex_aluOP),
      .ex_lvalue(ex_lvalue), .ex_rvalue(ex_rvalue), .ex_store_data(ex_store_data),
      .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic drive_id(input int v, input int op, input int rs, input int rt, input int rd,
                           input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                           input int ui, input int urt, input int rw, input int mr);
      id_valid    = 1'(v);
      id_aluOP    = 4'(op);
      id_rs       = 5'(rs);
      id_rt       = 5'(rt);
      id_rd       = 5'(rd);
      id_rs_data  = rsd;
      id_rt_data  = rtd;
      id_imm      = imm;
      id_use_imm  = 1'(ui);
      id_uses_rt  = 1'(urt);
      id_regwrite = 1'(rw);
      id_memread  = 1'(mr);
   endtask

   task automatic set_exmem(input int rw, input int rd, input logic [31:0] res);
      exmem_regwrite = 1'(rw);
      exmem_rd       = 5'(rd);
      exmem_result   = res;
   endtask

   task automatic set_memwb(input int rw, input int rd, input logic [31:0] res);
      memwb_regwrite = 1'(rw);
      memwb_rd       = 5'(rd);
      memwb_result   = res;
   endtask

   // advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0;
      stall   = 1'b0;
      flush   = 1'b0;
      set_exmem(0, 0, 32'h0);
      set_memwb(0, 0, 32'h0);
      drive_id(1, 15, 1, 2, 9, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC, 0, 1, 1, 1);
      #2;
      check_eq("rst_valid",    32'(ex_valid),    0);
      check_eq("rst_aluop",    32'(ex_aluOP),    0);
      check_eq("rst_rd",       32'(ex_rd),       0);
      check_eq("rst_regwrite", 32'(ex_regwrite), 0);
      check_eq("rst_memread",  32'(ex_memread),  0);
      check_eq("rst_lvalue",   ex_lvalue,        0);
      check_eq("rst_rvalue",   ex_rvalue,        0);
      check_eq("rst_store",    ex_store_data,    0);

      @(negedge clk);
      reset_n = 1'b1;
      drive_id(1, 5, 1, 2, 9, 32'h11, 32'h22, 32'h7, 1, 1, 1, 0);
      tick();
      #2;
      check_eq("ld_valid",    32'(ex_valid),    1);
      check_eq("ld_aluop",    32'(ex_aluOP),    5);
      check_eq("ld_lvalue",   ex_lvalue,        32'h11);
      check_eq("ld_rvalue",   ex_rvalue,        32'h7);
      check_eq("ld_store",    ex_store_data,    32'h22);
      check_eq("ld_rd",       32'(ex_rd),       9);
      check_eq("ld_regwrite", 32'(ex_regwrite), 1);
      check_eq("ld_memread",  32'(ex_memread),  0);

      // id_valid=0 gates writeback and load flags
      drive_id(0, 3, 1, 2, 10, 32'h1, 32'h2, 32'h0, 0, 1, 1, 1);
      tick();
      #2;
      check_eq("inv_valid",    32'(ex_valid),    0);
      check_eq("inv_regwrite", 32'(ex_regwrite), 0);
      check_eq("inv_memread",  32'(ex_memread),  0);

      // reset asserted while stalled: stage must emerge empty
      drive_id(1, 6, 1, 2, 11, 32'h61, 32'h62, 32'h0, 0, 1, 1, 0);
      tick();
      #2;
      check_eq("pre_rst_valid", 32'(ex_valid), 1);
      stall = 1'b1;
      reset_n = 1'b0;
      #1;
      check_eq("mid_rst_valid",  32'(ex_valid), 0);
      check_eq("mid_rst_lvalue", ex_lvalue,     0);
      check_eq("mid_rst_aluop",  32'(ex_aluOP), 0);
      #1;
      reset_n = 1'b1;
      tick();
      check_eq("rst_stall_empty", 32'(ex_valid), 0);
      stall = 1'b0;
      tick();
      #2;
      check_eq("post_rst_valid", 32'(ex_valid), 1);
      check_eq("post_rst_aluop", 32'(ex_aluOP), 6);

`ifdef EXEC_FWD_EN
      // back-to-back RAW forwarded from EX/MEM, which beats MEM/WB
      drive_id(1, 1, 1, 2, 3, 32'h1, 32'h2, 32'h0, 0, 1, 1, 0);
      tick();
      drive_id(1, 2, 3, 1, 4, 32'h5, 32'h1, 32'h0, 0, 1, 1, 0);
      #2;
      check_eq("raw_no_stall", 32'(hazard_stall), 0);
      tick();
      set_exmem(1, 3, 32'h10);
      set_memwb(1, 3, 32'h20);
      #2;
      check_eq("raw_exmem_lvalue", ex_lvalue,     32'h10);
      check_eq("raw_rvalue",       ex_rvalue,     32'h1);
      check_eq("raw_store",        ex_store_data, 32'h1);
      exmem_regwrite = 1'b0;
      #1;
      check_eq("raw_memwb_lvalue", ex_lvalue, 32'h20);
      set_exmem(0, 0, 32'h0);
      set_memwb(0, 0, 32'h0);
`else
      // RAW on r3 without forwarding: two stall cycles, then write-through
      drive_id(1, 1, 1, 2, 3, 32'h1, 32'h2, 32'h0, 0, 1, 1, 0);
      tick();
      drive_id(1, 2, 3, 1, 4, 32'h5, 32'h1, 32'h0, 0, 1, 1, 0);
      #2;
      check_eq("raw_stall1", 32'(hazard_stall), 1);
      tick();
      set_exmem(1, 3, 32'h10);
      #2;
      check_eq("raw_bubble1", 32'(ex_valid),     0);
      check_eq("raw_stall2",  32'(hazard_stall), 1);
      tick();
      set_exmem(0, 0, 32'h0);
      set_memwb(1, 3, 32'h30);
      #2;
      check_eq("raw_bubble2",  32'(ex_valid),     0);
      check_eq("raw_released", 32'(hazard_stall), 0);
      tick();
      set_memwb(0, 0, 32'h0);
      #2;
      check_eq("raw_wt_valid",  32'(ex_valid), 1);
      check_eq("raw_wt_lvalue", ex_lvalue,     32'h30);
`endif

      // load-use: lw r5 in EX, dependent add in ID
      drive_id(1, 0, 2, 0, 5, 32'h100, 32'h0, 32'h4, 1, 0, 1, 1);
      tick();
      check_eq("lw_memread", 32'(ex_memread), 1);
      drive_id(1, 1, 5, 0, 6, 32'h9, 32'h0, 32'h0, 0, 1, 1, 0);
      #2;
      check_eq("lu_stall", 32'(hazard_stall), 1);
      tick();
      set_exmem(1, 5, 32'hDEAD);
      #2;
      check_eq("lu_bubble", 32'(ex_valid), 0);
`ifdef EXEC_FWD_EN
      check_eq("lu_one_cycle", 32'(hazard_stall), 0);
      tick();
      set_exmem(0, 0, 32'h0);
      set_memwb(1, 5, 32'h55);
      #2;
      check_eq("lu_valid",  32'(ex_valid), 1);
      check_eq("lu_lvalue", ex_lvalue,     32'h55);
`else
      check_eq("lu_stall2", 32'(hazard_stall), 1);
      tick();
      set_exmem(0, 0, 32'h0);
      set_memwb(1, 5, 32'h55);
      #2;
      check_eq("lu_bubble2",  32'(ex_valid),     0);
      check_eq("lu_released", 32'(hazard_stall), 0);
      tick();
      set_memwb(0, 0, 32'h0);
      #2;
      check_eq("lu_valid",  32'(ex_valid), 1);
      check_eq("lu_lvalue", ex_lvalue,     32'h55);
`endif
      set_exmem(0, 0, 32'h0);
      set_memwb(0, 0, 32'h0);

      // $zero is never forwarded nor written through
      drive_id(1, 1, 0, 0, 12, 32'h0, 32'h0, 32'h0, 0, 1, 1, 0);
      set_exmem(1, 0, 32'hFFFF_FFFF);
      set_memwb(1, 0, 32'hFFFF_FFFF);
      #2;
      check_eq("zero_no_stall", 32'(hazard_stall), 0);
      tick();
      #2;
      check_eq("zero_lvalue", ex_lvalue,     0);
      check_eq("zero_store",  ex_store_data, 0);
      set_exmem(0, 0, 32'h0);
      set_memwb(0, 0, 32'h0);

      // stall for 3 edges while MEM/WB writes r7; latched rt must pick it up
      drive_id(1, 3, 0, 7, 8, 32'h0, 32'h1111, 32'h0, 0, 1, 1, 1);
      tick();
      #2;
      check_eq("snp_store_init", ex_store_data, 32'h1111);
      stall = 1'b1;
      drive_id(1, 9, 0, 7, 13, 32'h0, 32'h2222, 32'h0, 0, 1, 1, 0);
      tick();
      #2;
      check_eq("snp_hold_aluop", 32'(ex_aluOP), 3);
      set_memwb(1, 7, 32'hABCD);
      tick();
      set_memwb(0, 0, 32'h0);
      tick();
      stall = 1'b0;
      #2;
      check_eq("snp_store",  ex_store_data, 32'hABCD);
      check_eq("snp_rvalue", ex_rvalue,     32'hABCD);
      check_eq("snp_aluop",  32'(ex_aluOP), 3);
      check_eq("snp_rd",     32'(ex_rd),    8);

      // flush beats stall and masks the load-use request
      stall = 1'b1;
      flush = 1'b1;
      drive_id(1, 4, 8, 0, 14, 32'h0, 32'h0, 32'h0, 0, 1, 1, 0);
      #2;
      check_eq("fl_no_stall", 32'(hazard_stall), 0);
      tick();
      #2;
      check_eq("fl_valid",    32'(ex_valid),    0);
      check_eq("fl_rd",       32'(ex_rd),       0);
      check_eq("fl_regwrite", 32'(ex_regwrite), 0);
      check_eq("fl_aluop",    32'(ex_aluOP),    0);
      stall = 1'b0;
      flush = 1'b0;
      tick();
      #2;
      check_eq("fl_reload_valid", 32'(ex_valid), 1);
      check_eq("fl_reload_rd",    32'(ex_rd),    14);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
